// File: rtl/axis_rr_arbiter_if.sv
// Signal bundle between NUM_SRC AXI-Stream sources, the round-robin arbiter and its sink.
// The master modport is the arbiter's view; the slave modport is the surrounding sources/sink.
interface axis_rr_arbiter_if #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned T_DATA_W = 4,
    parameter int unsigned ID_W     = 2
);
    localparam int unsigned DataBits = 8 * T_DATA_W;

    logic [NUM_SRC*DataBits-1:0] s_tdata;
    logic [NUM_SRC*T_DATA_W-1:0] s_tkeep;
    logic [NUM_SRC-1:0]          s_tvalid;
    logic [NUM_SRC-1:0]          s_tlast;
    logic [NUM_SRC-1:0]          s_tready;

    logic [DataBits-1:0]         m_tdata;
    logic [T_DATA_W-1:0]         m_tkeep;
    logic                        m_tvalid;
    logic                        m_tlast;
    logic [ID_W-1:0]             m_tid;
    logic                        m_tready;
    logic                        overrun;

    modport master (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tid, overrun
    );

    modport slave (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tid, overrun
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-Stream sources onto one registered
// master port tagged with the source index; a beat watchdog truncates runaway packets.
module axis_rr_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned T_DATA_W  = 4,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned ID_W      = 2
) (
    input logic               aclk,
    input logic               aresetn,
    axis_rr_arbiter_if.master bus
);
    localparam int unsigned DataBits = 8 * T_DATA_W;
    localparam int unsigned SrcW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CntW     = $clog2(MAX_BEATS);
    localparam logic [SrcW-1:0] LastSrc = SrcW'(NUM_SRC - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StLock, StDrop} state_e;

    state_e              state_q, state_d;
    logic [SrcW-1:0]     grant_q, grant_d;
    logic [SrcW-1:0]     last_grant_q, last_grant_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [DataBits-1:0] m_tdata_q, m_tdata_d;
    logic [T_DATA_W-1:0] m_tkeep_q, m_tkeep_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic [ID_W-1:0]     m_tid_q, m_tid_d;
    logic                overrun_q, overrun_d;

    logic [NUM_SRC-1:0]  s_tready;
    logic                load_ok;
    logic                sel_valid, sel_last, at_max;
    logic [DataBits-1:0] sel_data;
    logic [T_DATA_W-1:0] sel_keep;
    logic                rr_found;
    logic [SrcW-1:0]     rr_pick, rr_cand;

    // Search starts one past the last packet owner, so the previous owner has lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_q;
        rr_cand  = last_grant_q;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            rr_cand = SrcW'((32'(last_grant_q) + k) % NUM_SRC);
            if (!rr_found && bus.s_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SrcW'(i)) begin
                sel_data = bus.s_tdata[i*DataBits +: DataBits];
                sel_keep = bus.s_tkeep[i*T_DATA_W +: T_DATA_W];
            end
        end
    end

    assign sel_valid = bus.s_tvalid[grant_q];
    assign sel_last  = bus.s_tlast[grant_q];
    assign at_max    = (beat_cnt_q == CntMax);
    assign load_ok   = ~m_tvalid_q | bus.m_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tvalid_d   = m_tvalid_q & ~bus.m_tready;
        m_tlast_d    = m_tlast_q;
        m_tid_d      = m_tid_q;
        overrun_d    = 1'b0;
        s_tready     = '0;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = StLock;
                end
            end
            StLock: begin
                s_tready[grant_q] = load_ok;
                if (sel_valid && load_ok) begin
                    m_tdata_d  = sel_data;
                    m_tkeep_d  = sel_keep;
                    m_tid_d    = ID_W'(grant_q);
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = sel_last | at_max;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = StIdle;
                    end else if (at_max) begin
                        // Downstream sees a clean end of packet; the tail is swallowed in StDrop.
                        overrun_d  = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = StDrop;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                s_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastSrc;
            beat_cnt_q   <= '0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tid_q      <= m_tid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.s_tready = s_tready;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tkeep  = m_tkeep_q;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tid    = m_tid_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: expected beats are queued when stimulus is loaded and a
// separate monitor pops and compares them whenever the master port transfers a beat.
module tb_axis_rr_arbiter;
    localparam int unsigned NumSrc   = 4;
    localparam int unsigned TDataW   = 4;
    localparam int unsigned MaxBeats = 16;
    localparam int unsigned IdW      = 2;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int unsigned gap;
    } src_beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  tid;
    } exp_beat_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    axis_rr_arbiter_if #(.NUM_SRC(NumSrc), .T_DATA_W(TDataW), .ID_W(IdW)) bus ();

    axis_rr_arbiter #(
        .NUM_SRC  (NumSrc),
        .T_DATA_W (TDataW),
        .MAX_BEATS(MaxBeats),
        .ID_W     (IdW)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    initial forever #5 aclk = ~aclk;

    src_beat_t   src_q [NumSrc][$];
    int unsigned wait_c [NumSrc];
    exp_beat_t   exp_q[$];
    int          beat_cyc[$];
    int          cyc;
    int          ovr_cnt;
    int          n_chk;
    int          n_pass;
    int          n_beat;
    logic        rdy_plan;
    logic [NumSrc-1:0] fire;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: samples just before the rising edge.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge aclk);
            #4;
            if (aresetn && bus.overrun) ovr_cnt++;
            if (aresetn && bus.m_tvalid && bus.m_tready) begin
                beat_cyc.push_back(cyc);
                n_beat++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got data %0h tid %0d, expected no beat",
                             bus.m_tdata, bus.m_tid);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d_data", n_beat), bus.m_tdata, e.data);
                    check($sformatf("beat%0d_keep", n_beat), bus.m_tkeep, e.keep);
                    check($sformatf("beat%0d_last", n_beat), bus.m_tlast, e.last);
                    check($sformatf("beat%0d_tid", n_beat), bus.m_tid, e.tid);
                end
            end
        end
    end

    task automatic step();
        src_beat_t b;
        @(negedge aclk);
        cyc++;
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (src_q[i].size() > 0 && wait_c[i] == 0) begin
                bus.s_tvalid[i]          = 1'b1;
                bus.s_tdata[i*32 +: 32]  = src_q[i][0].data;
                bus.s_tkeep[i*4 +: 4]    = src_q[i][0].keep;
                bus.s_tlast[i]           = src_q[i][0].last;
            end else begin
                bus.s_tvalid[i]          = 1'b0;
                bus.s_tdata[i*32 +: 32]  = '0;
                bus.s_tkeep[i*4 +: 4]    = '0;
                bus.s_tlast[i]           = 1'b0;
            end
            if (wait_c[i] > 0) wait_c[i]--;
        end
        bus.m_tready = rdy_plan;
        #4;
        fire = bus.s_tvalid & bus.s_tready;
        @(posedge aclk);
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (fire[i]) begin
                b = src_q[i].pop_front();
                if (src_q[i].size() > 0) wait_c[i] = src_q[i][0].gap;
            end
        end
    endtask

    task automatic push_src(input int src, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input int unsigned gap);
        src_beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.gap  = gap;
        if (src_q[src].size() == 0) wait_c[src] = gap;
        src_q[src].push_back(b);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic [1:0] id);
        exp_beat_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        e.tid  = id;
        exp_q.push_back(e);
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < int'(NumSrc); i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
            step();
            n++;
        end
        check({name, "_pending_beats"}, exp_q.size(), 0);
        repeat (2) step();
    endtask

    task automatic do_reset();
        aresetn      = 1'b0;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = '0;
        rdy_plan     = 1'b1;
        bus.m_tready = 1'b1;
        for (int i = 0; i < int'(NumSrc); i++) begin
            src_q[i].delete();
            wait_c[i] = 0;
        end
        repeat (3) @(negedge aclk);
        check("rst_m_tvalid", bus.m_tvalid, 0);
        check("rst_m_tlast", bus.m_tlast, 0);
        check("rst_m_tdata", bus.m_tdata, 0);
        check("rst_m_tid", bus.m_tid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_s_tready", bus.s_tready, 0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        int n;
        n_chk   = 0;
        n_pass  = 0;
        n_beat  = 0;
        cyc     = 0;
        ovr_cnt = 0;

        // Single 3-beat packet from src1.
        do_reset();
        push_src(1, 32'h11, 4'hF, 1'b0, 0);
        push_src(1, 32'h22, 4'hF, 1'b0, 0);
        push_src(1, 32'h33, 4'hF, 1'b1, 0);
        push_exp(32'h11, 4'hF, 1'b0, 2'd1);
        push_exp(32'h22, 4'hF, 1'b0, 2'd1);
        push_exp(32'h33, 4'hF, 1'b1, 2'd1);
        step();
        #1;
        check("t1_s_tready_cycle1", bus.s_tready, 4'b0010);
        drain("t1", 50);

        // All sources valid, 2-beat packets: rotation 0,1,2,3,0 with one idle cycle between.
        do_reset();
        beat_cyc.delete();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (p == 0 || s == 0) begin
                    for (int b = 0; b < 2; b++) begin
                        push_src(s, 32'hA000_0000 | (s << 8) | (p << 4) | b,
                                 (s == 3 && b == 0) ? 4'h0 : 4'hF, b == 1, 0);
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (p == 0 || s == 0) begin
                    for (int b = 0; b < 2; b++) begin
                        push_exp(32'hA000_0000 | (s << 8) | (p << 4) | b,
                                 (s == 3 && b == 0) ? 4'h0 : 4'hF, b == 1, 2'(s));
                    end
                end
            end
        end
        drain("t2", 100);
        check("t2_beat_count", beat_cyc.size(), 10);
        if (beat_cyc.size() == 10) begin
            for (int j = 1; j < 10; j++) begin
                check($sformatf("t2_beat%0d_cycle", j), beat_cyc[j] - beat_cyc[0],
                      (j / 2) * 3 + (j % 2));
            end
        end

        // Backpressure stall on src2 after its first beat.
        push_src(2, 32'hAABBCCDD, 4'hF, 1'b0, 0);
        push_src(2, 32'hDEADBEEF, 4'hF, 1'b1, 0);
        push_exp(32'hAABBCCDD, 4'hF, 1'b0, 2'd2);
        push_exp(32'hDEADBEEF, 4'hF, 1'b1, 2'd2);
        n = 0;
        while (!bus.m_tvalid && n < 20) begin
            step();
            #1;
            n++;
        end
        check("t3_first_valid", bus.m_tvalid, 1);
        check("t3_first_data", bus.m_tdata, 32'hAABBCCDD);
        rdy_plan = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            check($sformatf("t3_stall%0d_valid", c), bus.m_tvalid, 1);
            check($sformatf("t3_stall%0d_data", c), bus.m_tdata, 32'hAABBCCDD);
            check($sformatf("t3_stall%0d_s_tready", c), bus.s_tready, 0);
        end
        rdy_plan = 1'b1;
        drain("t3", 50);

        // Runaway src0 packet truncated at MaxBeats; src1 served after the tail is dropped.
        ovr_cnt = 0;
        for (int k = 1; k <= 20; k++) push_src(0, 32'h100 + k, 4'hF, k == 20, 0);
        push_src(1, 32'h5100, 4'hF, 1'b0, 0);
        push_src(1, 32'h5101, 4'h3, 1'b1, 0);
        for (int k = 1; k <= 16; k++) push_exp(32'h100 + k, 4'hF, k == 16, 2'd0);
        push_exp(32'h5100, 4'hF, 1'b0, 2'd1);
        push_exp(32'h5101, 4'h3, 1'b1, 2'd1);
        drain("t4", 150);
        check("t4_overrun_pulses", ovr_cnt, 1);

        // Reset mid-packet on src3; src0 wins the first arbitration afterwards.
        for (int k = 1; k <= 4; k++) push_src(3, 32'h3000_0000 + k, 4'hF, k == 4, 0);
        push_exp(32'h3000_0001, 4'hF, 1'b0, 2'd3);
        push_exp(32'h3000_0002, 4'hF, 1'b0, 2'd3);
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            step();
            n++;
        end
        check("t5_prefix_beats", exp_q.size(), 0);
        #1;
        aresetn = 1'b0;
        #1;
        check("t5_async_m_tvalid", bus.m_tvalid, 0);
        check("t5_async_s_tready", bus.s_tready, 0);
        bus.s_tvalid = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            src_q[i].delete();
            wait_c[i] = 0;
        end
        #6;
        aresetn = 1'b1;
        push_src(3, 32'h3333_0000, 4'h0, 1'b1, 0);
        push_src(0, 32'h0E00_0001, 4'hF, 1'b0, 0);
        push_src(0, 32'h0E00_0002, 4'hF, 1'b1, 0);
        push_exp(32'h0E00_0001, 4'hF, 1'b0, 2'd0);
        push_exp(32'h0E00_0002, 4'hF, 1'b1, 2'd0);
        push_exp(32'h3333_0000, 4'h0, 1'b1, 2'd3);
        drain("t5", 60);

        // src1 pauses 3 cycles mid-packet; lock is kept and src2 follows.
        beat_cyc.delete();
        push_src(1, 32'h1600_0001, 4'hF, 1'b0, 0);
        push_src(1, 32'h1600_0002, 4'hF, 1'b0, 0);
        push_src(1, 32'h1600_0003, 4'hF, 1'b0, 3);
        push_src(1, 32'h1600_0004, 4'hF, 1'b1, 0);
        push_src(2, 32'h2600_0001, 4'hF, 1'b0, 0);
        push_src(2, 32'h2600_0002, 4'hF, 1'b1, 0);
        for (int k = 1; k <= 4; k++) push_exp(32'h1600_0000 + k, 4'hF, k == 4, 2'd1);
        push_exp(32'h2600_0001, 4'hF, 1'b0, 2'd2);
        push_exp(32'h2600_0002, 4'hF, 1'b1, 2'd2);
        drain("t6", 80);
        check("t6_beat_count", beat_cyc.size(), 6);
        if (beat_cyc.size() == 6) begin
            check("t6_b2_after_b1", beat_cyc[1] - beat_cyc[0], 1);
            check("t6_gap_cycles", beat_cyc[2] - beat_cyc[1], 4);
            check("t6_b4_after_b3", beat_cyc[3] - beat_cyc[2], 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
